// File: rtl/wma_filter_mc_if.sv
// Sample-in / result-out streams of the weighted-moving-average filter.
// slave is the filter's view, master is the producer/consumer side.
interface wma_filter_mc_if #(
    parameter int WIDTH = 8,
    parameter int CH_W  = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [CH_W-1:0]  in_ch;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_ch;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_zone;

    modport slave (
        input  in_valid, in_ch, in_data, out_ready,
        output in_ready, out_valid, out_ch, out_data, out_zone
    );

    modport master (
        output in_valid, in_ch, in_data, out_ready,
        input  in_ready, out_valid, out_ch, out_data, out_zone
    );
endinterface

// File: rtl/wma_filter_mc.sv
// Multi-channel zone-weighted moving average: 2 edges from accept to out_valid, 1 sample/cycle.
// in_ready drops only when stage 1 is stuck behind a held output or clear is high.
module wma_filter_mc #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SHIFT    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] t1,
    input  logic [WIDTH-1:0] t2,
    input  logic [SHIFT:0]   w_low,
    input  logic [SHIFT:0]   w_mid,
    input  logic [SHIFT:0]   w_high,
    wma_filter_mc_if.slave   bus
);
    localparam int CH_W  = $clog2(CHANNELS);
    localparam int ACC_W = WIDTH + SHIFT + 1;
    localparam logic [SHIFT:0]   W_ONE = {1'b1, {SHIFT{1'b0}}};
    localparam logic [ACC_W-1:0] HALF  = ACC_W'(W_ONE) >> 1;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] prev;
        logic             seed;
        logic [SHIFT:0]   w;
        logic [1:0]       zone;
    } s1_t;

    logic [WIDTH-1:0]    avg_q [CHANNELS];
    logic [CHANNELS-1:0] seed_q;

    logic       s1_vld_q, s1_vld_d;
    s1_t        s1_q, s1_d;
    logic             out_vld_q, out_vld_d;
    logic [CH_W-1:0]  out_ch_q, out_ch_d;
    logic [WIDTH-1:0] out_dat_q, out_dat_d;
    logic [1:0]       out_zone_q, out_zone_d;

    logic             s1_moves, in_rdy, accept, in_range, fwd;
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] s1_res, prev_sel;
    logic             seed_sel;
    logic [1:0]       zone;
    logic [SHIFT:0]   w_sel, w_sat;

    assign s1_moves = s1_vld_q && (!out_vld_q || bus.out_ready);
    assign in_rdy   = !clear && (!s1_vld_q || s1_moves);
    assign accept   = bus.in_valid && in_rdy;
    assign in_range = {1'b0, bus.in_ch} < (CH_W+1)'(CHANNELS);

    assign acc    = ACC_W'(s1_q.w) * ACC_W'(s1_q.x)
                  + ACC_W'(W_ONE - s1_q.w) * ACC_W'(s1_q.prev) + HALF;
    assign s1_res = s1_q.seed ? WIDTH'(acc >> SHIFT) : s1_q.x;

    // A same-channel entry leaving stage 1 this edge holds the true history.
    assign fwd      = s1_moves && (s1_q.ch == bus.in_ch);
    assign prev_sel = fwd ? s1_res : avg_q[bus.in_ch];
    assign seed_sel = fwd ? 1'b1   : seed_q[bus.in_ch];

    always_comb begin
        zone  = 2'd2;
        w_sel = w_high;
        if (bus.in_data < t1) begin
            zone  = 2'd0;
            w_sel = w_low;
        end else if (bus.in_data < t2) begin
            zone  = 2'd1;
            w_sel = w_mid;
        end
        w_sat = (w_sel > W_ONE) ? W_ONE : w_sel;
    end

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_d       = s1_q;
        out_vld_d  = out_vld_q;
        out_ch_d   = out_ch_q;
        out_dat_d  = out_dat_q;
        out_zone_d = out_zone_q;
        if (s1_moves) s1_vld_d = 1'b0;
        if (accept) begin
            s1_vld_d = in_range;
            s1_d     = '{ch: bus.in_ch, x: bus.in_data, prev: prev_sel,
                         seed: seed_sel, w: w_sat, zone: zone};
        end
        if (s1_moves) begin
            out_vld_d  = 1'b1;
            out_ch_d   = s1_q.ch;
            out_dat_d  = s1_res;
            out_zone_d = s1_q.zone;
        end else if (bus.out_ready) begin
            out_vld_d = 1'b0;
        end
        if (clear) begin
            s1_vld_d  = 1'b0;
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_q       <= '0;
            out_vld_q  <= 1'b0;
            out_ch_q   <= '0;
            out_dat_q  <= '0;
            out_zone_q <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_q       <= s1_d;
            out_vld_q  <= out_vld_d;
            out_ch_q   <= out_ch_d;
            out_dat_q  <= out_dat_d;
            out_zone_q <= out_zone_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            for (int i = 0; i < CHANNELS; i++) avg_q[i] <= '0;
            seed_q <= '0;
        end else if (s1_moves) begin
            avg_q[s1_q.ch]  <= s1_res;
            seed_q[s1_q.ch] <= 1'b1;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_data  = out_dat_q;
    assign bus.out_zone  = out_zone_q;
endmodule

// File: tb/tb_wma_filter_mc.sv
// Directed bench for wma_filter_mc: seeding, zone blends, forwarding, backpressure, clear, async reset.
module tb_wma_filter_mc;
    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       clear  = 1'b0;
    logic [7:0] t1     = 8'd20;
    logic [7:0] t2     = 8'd60;
    logic [3:0] w_low  = 4'd2;
    logic [3:0] w_mid  = 4'd6;
    logic [3:0] w_high = 4'd15;
    int checks   = 0;
    int failures = 0;

    wma_filter_mc_if #(.WIDTH(8), .CH_W(2)) bus ();

    wma_filter_mc #(.WIDTH(8), .CHANNELS(4), .SHIFT(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .t1     (t1),
        .t2     (t2),
        .w_low  (w_low),
        .w_mid  (w_mid),
        .w_high (w_high),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] ch, input logic [7:0] d,
                           input logic [1:0] z);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".ch"},    32'(bus.out_ch),    32'(ch));
        chk({tag, ".data"},  32'(bus.out_data),  32'(d));
        chk({tag, ".zone"},  32'(bus.out_zone),  32'(z));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_ch    = ch;
        bus.in_data  = d;
    endtask

    initial begin
        drive(1'b0, 2'd0, 8'd0);
        bus.out_ready = 1'b1;
        #2;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data",  32'(bus.out_data),  32'd0);
        chk("rst_ch",    32'(bus.out_ch),    32'd0);
        chk("rst_zone",  32'(bus.out_zone),  32'd0);
        #20 rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // first sample of a channel passes straight through
        drive(1'b1, 2'd2, 8'd100);
        tick();
        drive(1'b0, 2'd0, 8'd0);
        chk("lat_edge1", 32'(bus.out_valid), 32'd0);
        tick();
        chk_out("seed_ch2", 2'd2, 8'd100, 2'd2);
        tick();
        chk("drain_ch2", 32'(bus.out_valid), 32'd0);

        // ch0: 40 seeds, 48 mid (6*48+2*40+4)>>3=46, 10 low (2*10+6*46+4)>>3=37
        drive(1'b1, 2'd0, 8'd40);
        tick();
        drive(1'b1, 2'd0, 8'd48);
        tick();
        chk_out("seed_ch0", 2'd0, 8'd40, 2'd1);
        drive(1'b1, 2'd0, 8'd10);
        tick();
        chk_out("mid_blend", 2'd0, 8'd46, 2'd1);
        drive(1'b0, 2'd0, 8'd0);
        tick();
        chk_out("low_fwd", 2'd0, 8'd37, 2'd0);
        tick();

        // ch1: seed 30, then high zone with weight 15 saturating to 8
        drive(1'b1, 2'd1, 8'd30);
        tick();
        drive(1'b1, 2'd1, 8'd200);
        tick();
        chk_out("seed_ch1", 2'd1, 8'd30, 2'd1);
        drive(1'b0, 2'd0, 8'd0);
        tick();
        chk_out("w_sat", 2'd1, 8'd200, 2'd2);
        tick();

        // backpressure on ch3: 50, 58->56, 10->45, 70->70
        bus.out_ready = 1'b0;
        drive(1'b1, 2'd3, 8'd50);
        tick();
        drive(1'b1, 2'd3, 8'd58);
        #1 chk("bp_rdy_open", 32'(bus.in_ready), 32'd1);
        tick();
        chk_out("bp_a", 2'd3, 8'd50, 2'd1);
        drive(1'b1, 2'd3, 8'd10);
        #1 chk("bp_rdy_full", 32'(bus.in_ready), 32'd0);
        tick();
        chk_out("bp_hold1", 2'd3, 8'd50, 2'd1);
        chk("bp_rdy_full2", 32'(bus.in_ready), 32'd0);
        tick();
        chk_out("bp_hold2", 2'd3, 8'd50, 2'd1);
        bus.out_ready = 1'b1;
        #1 chk("bp_rdy_release", 32'(bus.in_ready), 32'd1);
        tick();
        chk_out("bp_b", 2'd3, 8'd56, 2'd1);
        drive(1'b1, 2'd3, 8'd70);
        tick();
        chk_out("bp_c", 2'd3, 8'd45, 2'd0);
        drive(1'b0, 2'd0, 8'd0);
        tick();
        chk_out("bp_d", 2'd3, 8'd70, 2'd2);
        tick();
        chk("bp_drain", 32'(bus.out_valid), 32'd0);

        // clear with output and stage 1 both occupied
        drive(1'b1, 2'd0, 8'd33);
        tick();
        drive(1'b1, 2'd1, 8'd40);
        tick();
        chk_out("pre_clear", 2'd0, 8'd34, 2'd1);
        bus.out_ready = 1'b0;
        clear = 1'b1;
        drive(1'b1, 2'd2, 8'd99);
        #1 chk("clr_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("clr_drop", 32'(bus.out_valid), 32'd0);
        clear = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 2'd1, 8'd40);
        #1 chk("clr_rdy_after", 32'(bus.in_ready), 32'd1);
        tick();
        chk("clr_no_accept", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 2'd0, 8'd50);
        tick();
        chk_out("reseed_ch1", 2'd1, 8'd40, 2'd1);
        drive(1'b0, 2'd0, 8'd0);
        tick();
        chk_out("reseed_ch0", 2'd0, 8'd50, 2'd1);
        tick();

        // async reset with a held output and a full stage 1
        bus.out_ready = 1'b0;
        drive(1'b1, 2'd2, 8'd60);
        tick();
        drive(1'b1, 2'd2, 8'd61);
        tick();
        chk_out("pre_rst", 2'd2, 8'd60, 2'd2);
        drive(1'b0, 2'd0, 8'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_data",  32'(bus.out_data),  32'd0);
        chk("arst_ch",    32'(bus.out_ch),    32'd0);
        chk("arst_zone",  32'(bus.out_zone),  32'd0);
        #2 rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("arst_flush", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 2'd2, 8'd30);
        tick();
        drive(1'b0, 2'd0, 8'd0);
        tick();
        chk_out("arst_reseed", 2'd2, 8'd30, 2'd1);
        tick();

        // inverted thresholds: mid zone unreachable; 50 low: (2*50+6*90+4)>>3=80
        t1 = 8'd80;
        t2 = 8'd30;
        drive(1'b1, 2'd3, 8'd90);
        tick();
        drive(1'b1, 2'd3, 8'd50);
        tick();
        chk_out("inv_high", 2'd3, 8'd90, 2'd2);
        drive(1'b0, 2'd0, 8'd0);
        tick();
        chk_out("inv_low", 2'd3, 8'd80, 2'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
